sprite_reg_arbiter: RTL and testbench

- Owns the single read/write port of the sprite register file and shares it between two requesters: the CPU bus and an internal per-frame snapshot sequencer.
- On each frame-start pulse the sequencer checks the frame lock register (addr 22).
- If the lock is clear, it streams sprite registers 0..SNAP_LAST to the renderer shadow latches.
- The CPU has priority, with a bounded starvation limit that guarantees the snapshot makes progress.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_reg_arbiter_port.sv | 66 ++++++
 rtl/sprite_reg_arbiter.sv | 153 +++++++++++++++
 tb/tb_sprite_reg_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types and address map for the sprite register block.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKCHK = 2'd1,
        ST_SCAN    = 2'd2
    } spr_state_t;

    localparam int SPR_LOCK_ADDR = 22;
    localparam int SPR_SNAP_LAST = 21;

    // Register address map: sprite/score block followed by a status window.
    localparam logic [5:0] SPR_ADDR_SPRITE_FIRST = 6'd0;
    localparam logic [5:0] SPR_ADDR_SPRITE_LAST  = 6'd27;
    localparam logic [5:0] SPR_ADDR_STATUS_FIRST = 6'd32;
    localparam logic [5:0] SPR_ADDR_STATUS_LAST  = 6'd35;

    function automatic logic spr_is_mapped(input logic [5:0] addr);
        return (addr <= SPR_ADDR_SPRITE_LAST) ||
               ((addr >= SPR_ADDR_STATUS_FIRST) && (addr <= SPR_ADDR_STATUS_LAST));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_reg_arbiter_port.sv
`default_nettype none
// ============================================================================
// Module      : sprite_port_arbiter
// Description : CPU-priority grant logic with starvation bound, and the
//               register-file port mux shared by the CPU and the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_port_arbiter
    import sprite_pkg::*;
#(
    parameter int LOCK_ADDR  = SPR_LOCK_ADDR,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_scan_pend,
    input  logic        i_scan_lock,
    input  logic [4:0]  i_scan_idx,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [5:0]  i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic        o_cpu_grant,
    output logic        o_scan_grant,
    output logic [5:0]  o_rf_addr,
    output logic [15:0] o_rf_wdata,
    output logic        o_rf_we
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);
    localparam logic [5:0] c_lock_addr  = 6'(LOCK_ADDR);

    logic [3:0] r_starve_cnt;
    logic       w_starved;

    // The CPU only loses the port once it has starved a pending scan for
    // STARVE_MAX consecutive cycles.
    assign w_starved    = i_scan_pend && (r_starve_cnt == c_starve_max);
    assign o_cpu_grant  = i_cpu_req && !w_starved;
    assign o_scan_grant = i_scan_pend && !o_cpu_grant;

    always_comb begin
        o_rf_addr  = 6'd0;
        o_rf_wdata = 16'd0;
        o_rf_we    = 1'b0;
        if (o_cpu_grant) begin
            o_rf_addr  = i_cpu_addr;
            o_rf_wdata = i_cpu_wdata;
            o_rf_we    = i_cpu_we;
        end else if (o_scan_grant) begin
            o_rf_addr  = i_scan_lock ? c_lock_addr : {1'b0, i_scan_idx};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_scan_pend || o_scan_grant) begin
            r_starve_cnt <= 4'd0;
        end else if (o_cpu_grant && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_reg_arbiter
// Description : Shares the sprite register file port between the CPU and a
//               per-frame snapshot sequencer feeding the renderer latches.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_reg_arbiter
    import sprite_pkg::*;
#(
    parameter int SNAP_LAST  = SPR_SNAP_LAST,
    parameter int LOCK_ADDR  = SPR_LOCK_ADDR,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [5:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        vsync,
    output logic [5:0]  rf_addr,
    output logic [15:0] rf_wdata,
    output logic        rf_we,
    input  logic [15:0] rf_rdata,
    output logic        snap_valid,
    output logic [4:0]  snap_idx,
    output logic [7:0]  snap_data,
    output logic        snap_done,
    output logic        snap_skip,
    output logic        snap_overrun,
    output logic        busy
);

    localparam logic [4:0] c_snap_last = 5'(SNAP_LAST);

    spr_state_t r_state, w_state_nxt;
    logic [4:0] r_idx, w_idx_nxt;
    logic       r_snap_valid, w_snap_valid_nxt;
    logic [4:0] r_snap_idx, w_snap_idx_nxt;
    logic [7:0] r_snap_data, w_snap_data_nxt;
    logic       r_snap_done, w_snap_done_nxt;
    logic       r_snap_skip, w_snap_skip_nxt;
    logic       r_snap_overrun, w_snap_overrun_nxt;
    logic       w_scan_pend;
    logic       w_scan_grant;
    logic       w_cpu_grant;

    assign w_scan_pend = (r_state != ST_IDLE);

    sprite_port_arbiter #(
        .LOCK_ADDR  (LOCK_ADDR),
        .STARVE_MAX (STARVE_MAX)
    ) u_port_arbiter (
        .clk          (clk),
        .reset        (reset),
        .i_scan_pend  (w_scan_pend),
        .i_scan_lock  (r_state == ST_LOCKCHK),
        .i_scan_idx   (r_idx),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_grant  (w_cpu_grant),
        .o_scan_grant (w_scan_grant),
        .o_rf_addr    (rf_addr),
        .o_rf_wdata   (rf_wdata),
        .o_rf_we      (rf_we)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_snap_valid_nxt   = 1'b0;
        w_snap_idx_nxt     = r_snap_idx;
        w_snap_data_nxt    = r_snap_data;
        w_snap_done_nxt    = 1'b0;
        w_snap_skip_nxt    = 1'b0;
        // A late vsync is only reported; the scan in flight is not restarted.
        w_snap_overrun_nxt = vsync && (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (vsync) begin
                    w_state_nxt = ST_LOCKCHK;
                end
            end
            ST_LOCKCHK: begin
                if (w_scan_grant) begin
                    if (rf_rdata[7:0] != 8'd0) begin
                        w_snap_skip_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_state_nxt     = ST_SCAN;
                        w_idx_nxt       = 5'd0;
                    end
                end
            end
            ST_SCAN: begin
                if (w_scan_grant) begin
                    w_snap_valid_nxt = 1'b1;
                    w_snap_idx_nxt   = r_idx;
                    w_snap_data_nxt  = rf_rdata[7:0];
                    if (r_idx == c_snap_last) begin
                        w_snap_done_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                        w_idx_nxt       = 5'd0;
                    end else begin
                        w_idx_nxt       = r_idx + 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= 5'd0;
            r_snap_valid   <= 1'b0;
            r_snap_idx     <= 5'd0;
            r_snap_data    <= 8'd0;
            r_snap_done    <= 1'b0;
            r_snap_skip    <= 1'b0;
            r_snap_overrun <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_snap_valid   <= w_snap_valid_nxt;
            r_snap_idx     <= w_snap_idx_nxt;
            r_snap_data    <= w_snap_data_nxt;
            r_snap_done    <= w_snap_done_nxt;
            r_snap_skip    <= w_snap_skip_nxt;
            r_snap_overrun <= w_snap_overrun_nxt;
        end
    end

    assign cpu_ack      = w_cpu_grant;
    assign cpu_rdata    = rf_rdata;
    assign snap_valid   = r_snap_valid;
    assign snap_idx     = r_snap_idx;
    assign snap_data    = r_snap_data;
    assign snap_done    = r_snap_done;
    assign snap_skip    = r_snap_skip;
    assign snap_overrun = r_snap_overrun;
    assign busy         = w_scan_pend;

endmodule
`default_nettype wire

// File: tb/tb_sprite_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_reg_arbiter
// Description : Self-checking bench: register-file model, cycle compare
//               against a frame-level model, and directed frame scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_reg_arbiter;

    localparam int STARVE = 4;
    localparam int LAST   = 21;
    localparam int LOCK   = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, vsync = 1'b0;
    logic [5:0]  cpu_addr = 6'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic        cpu_ack, rf_we, snap_valid, snap_done, snap_skip, snap_overrun, busy;
    logic [15:0] cpu_rdata, rf_wdata, rf_rdata;
    logic [5:0]  rf_addr;
    logic [4:0]  snap_idx;
    logic [7:0]  snap_data;

    logic [15:0] rf_mem [64] = '{default: 16'h0000};
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_reg_arbiter #(.SNAP_LAST(LAST), .LOCK_ADDR(LOCK), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .vsync(vsync),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata),
        .snap_valid(snap_valid), .snap_idx(snap_idx), .snap_data(snap_data),
        .snap_done(snap_done), .snap_skip(snap_skip), .snap_overrun(snap_overrun), .busy(busy)
    );

    int n_checks = 0, n_err = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: is a frame in progress, what it reads next
    // (-1 = the lock register), and how long the CPU has been holding it off.
    bit m_active = 0;
    int m_pos = -1;
    int m_streak = 0;
    bit e_valid = 0, e_done = 0, e_skip = 0, e_over = 0;
    int e_idx = 0, e_data = 0;

    // Observed event log for the directed scenarios.
    int bq_idx[$], bq_data[$], bq_cyc[$];
    int done_cnt = 0, done_cyc = -1, skip_cnt = 0, over_cnt = 0, over_cyc = -1;

    always @(negedge clk) begin : cmp
        bit g_cpu, g_scan, was_active;
        int ea;
        if (!reset) begin
            m_active = 0; m_pos = -1; m_streak = 0;
            e_valid = 0; e_done = 0; e_skip = 0; e_over = 0; e_idx = 0; e_data = 0;
        end
        g_cpu  = cpu_req && !(m_active && m_streak == STARVE);
        g_scan = m_active && !g_cpu;
        ea = g_cpu ? int'(cpu_addr) : (g_scan ? (m_pos < 0 ? LOCK : m_pos) : 0);
        check("cpu_ack", 32'(cpu_ack), 32'(g_cpu));
        check("rf_addr", 32'(rf_addr), 32'(ea));
        check("rf_we", 32'(rf_we), 32'(g_cpu && cpu_we));
        if (g_cpu && cpu_we) check("rf_wdata", 32'(rf_wdata), 32'(cpu_wdata));
        check("busy", 32'(busy), 32'(m_active));
        check("snap_valid", 32'(snap_valid), 32'(e_valid));
        check("snap_done", 32'(snap_done), 32'(e_done));
        check("snap_skip", 32'(snap_skip), 32'(e_skip));
        check("snap_overrun", 32'(snap_overrun), 32'(e_over));
        if (e_valid || !reset) begin
            check("snap_idx", 32'(snap_idx), 32'(e_idx));
            check("snap_data", 32'(snap_data), 32'(e_data));
        end
        if (reset) begin
            if (snap_valid) begin
                bq_idx.push_back(int'(snap_idx)); bq_data.push_back(int'(snap_data)); bq_cyc.push_back(cyc);
            end
            if (snap_done) begin done_cnt++; done_cyc = cyc; end
            if (snap_skip) skip_cnt++;
            if (snap_overrun) begin over_cnt++; over_cyc = cyc; end
            was_active = m_active;
            e_valid = 0; e_done = 0; e_skip = 0;
            e_over = vsync && m_active;
            if (g_scan) begin
                if (m_pos < 0) begin
                    if (rf_mem[6'(LOCK)][7:0] != 8'd0) begin e_skip = 1; m_active = 0; end
                    else m_pos = 0;
                end else begin
                    e_valid = 1; e_idx = m_pos; e_data = int'(rf_mem[6'(m_pos)][7:0]);
                    if (m_pos == LAST) begin e_done = 1; m_active = 0; end
                    else m_pos++;
                end
            end else if (!m_active && vsync) begin
                m_active = 1; m_pos = -1;
            end
            if (!was_active || g_scan) m_streak = 0;
            else if (g_cpu && m_streak < STARVE) m_streak++;
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic goto_cycle(input int c);
        for (int g = 0; g < 2000 && cyc < c; g++) next_cycle();
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
        bit acked = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(negedge clk);
            if (cpu_ack) acked = 1;
        end
        if (!acked) check("cpu_write_ack_timeout", 32'(acked), 32'd1);
        next_cycle();
        cpu_req = 0; cpu_we = 0;
    endtask

    task automatic pulse_vsync(output int t);
        vsync = 1; t = cyc;
        next_cycle();
        vsync = 0;
    endtask

    task automatic clear_log();
        bq_idx.delete(); bq_data.delete(); bq_cyc.delete();
        done_cnt = 0; done_cyc = -1; skip_cnt = 0; over_cnt = 0; over_cyc = -1;
    endtask

    task automatic check_full_frame(input string tag, input int t, input bit timed);
        check({tag, "_beats"}, 32'(bq_idx.size()), 32'd22);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < bq_idx.size() && i < 22; i++) begin
            check({tag, "_order"}, 32'(bq_idx[i]), 32'(i));
            if (timed) check({tag, "_beat_cycle"}, 32'(bq_cyc[i]), 32'(t + 3 + i));
        end
    endtask

    int  t;
    bit  ack_pat [20];

    initial begin
        repeat (3) next_cycle();
        reset = 1;
        next_cycle();
        for (int k = 0; k < 22; k++) cpu_write(6'(k), 16'(16'h0040 + k));
        cpu_write(6'(LOCK), 16'h0000);

        // Async reset in the middle of a scan (idx 7 pending in cycle t+9).
        clear_log();
        pulse_vsync(t);
        goto_cycle(t + 9);
        check("pre_reset_valid", 32'(snap_valid), 32'd1);
        #2 reset = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(snap_valid), 32'd0);
        check("rst_idx", 32'(snap_idx), 32'd0);
        check("rst_data", 32'(snap_data), 32'd0);
        next_cycle(); next_cycle();
        reset = 1;
        next_cycle();

        // Clean frame, no CPU traffic.
        clear_log();
        pulse_vsync(t);
        goto_cycle(t + 27);
        check_full_frame("nominal", t, 1'b1);
        check("nominal_done_cycle", 32'(done_cyc), 32'(t + 24));
        if (bq_data.size() == 22) begin
            check("nominal_data0", 32'(bq_data[0]), 32'h40);
            check("nominal_data21", 32'(bq_data[21]), 32'h55);
        end

        // Locked frame is skipped.
        cpu_write(6'(LOCK), 16'h0001);
        clear_log();
        pulse_vsync(t);
        @(negedge clk);
        check("lock_rf_addr", 32'(rf_addr), 32'd22);
        next_cycle();
        @(negedge clk);
        check("lock_skip", 32'(snap_skip), 32'd1);
        check("lock_busy", 32'(busy), 32'd0);
        goto_cycle(t + 8);
        check("lock_no_beats", 32'(bq_idx.size()), 32'd0);
        check("lock_skip_cnt", 32'(skip_cnt), 32'd1);
        cpu_write(6'(LOCK), 16'h0000);

        // CPU saturating the port: 4 CPU grants then 1 scan grant.
        clear_log();
        pulse_vsync(t);
        goto_cycle(t + 2);
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'd30;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ack_pat[i] = cpu_ack;
            next_cycle();
        end
        cpu_req = 0;
        for (int i = 0; i < 20; i++) check("starve_pattern", 32'(ack_pat[i]), 32'((i % 5) != 4));
        goto_cycle(t + 50);
        check_full_frame("starve", t, 1'b0);

        // CPU writes racing the scan.
        clear_log();
        pulse_vsync(t);
        goto_cycle(t + 5);
        cpu_write(6'd10, 16'h0099);
        goto_cycle(t + 8);
        cpu_write(6'd2, 16'h0077);
        goto_cycle(t + 10);
        cpu_write(6'(LOCK), 16'h0001);
        goto_cycle(t + 35);
        check_full_frame("race", t, 1'b0);
        if (bq_data.size() == 22) begin
            check("race_data10", 32'(bq_data[10]), 32'h99);
            check("race_data2", 32'(bq_data[2]), 32'h42);
            check("race_data11", 32'(bq_data[11]), 32'h4B);
        end
        cpu_write(6'(LOCK), 16'h0000);
        cpu_write(6'd10, 16'h004A);
        cpu_write(6'd2, 16'h0042);

        // Second vsync mid-scan: overrun flagged, no restart.
        clear_log();
        pulse_vsync(t);
        goto_cycle(t + 10);
        vsync = 1;
        next_cycle();
        vsync = 0;
        goto_cycle(t + 30);
        check_full_frame("overrun", t, 1'b1);
        check("overrun_cnt", 32'(over_cnt), 32'd1);
        check("overrun_cycle", 32'(over_cyc), 32'(t + 11));
        check("overrun_done_cycle", 32'(done_cyc), 32'(t + 24));
        @(negedge clk);
        check("overrun_idle_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
